ram_bist_ctrl: RTL

- Initiator-side controller for the 8x8 synchronous RAM; drives its write_en/addr/data_in and reads back data_out.
- On a start pulse, runs a 4-element March test (write, read/invert, reverse read/invert, final read) over every address.
- Reports pass/fail plus first-failure details.
- Sits between system control and the RAM, using the RAM's existing port set as a bus master.

---
 rtl/ram_bist_pkg.sv | 24 ++
 rtl/ram_bist_addr_gen.sv | 37 +++
 rtl/ram_bist_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
// Shared encodings for the RAM March BIST: FSM states, March element table, and
// the read-latency range check.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0_WR,
    ST_RD,
    ST_WR,
    ST_FIN,
    ST_DONE
  } state_e;

  // Per-element attributes, indexed by element number (bit 0 = el0 ... bit 3 = el3).
  localparam logic [3:0] EL_DOWN    = 4'b0100;  // el2 walks addresses downward
  localparam logic [3:0] EL_EXP_INV = 4'b0100;  // el2 expects ~BG, el1/el3 expect BG
  localparam logic [3:0] EL_HAS_WR  = 4'b0110;  // el1/el2 follow each read with a write
  localparam logic [3:0] EL_WR_INV  = 4'b0010;  // el1 writes ~BG, el2 writes BG back

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= 0) && (lat <= 3);
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the March walk: loads 0 or all-ones, and flags
// the terminal address for the current direction.
module ram_bist_addr_gen #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              term_o
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ONE) : (addr_q + ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr_o = addr_q;
  assign term_o = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST initiator for a small synchronous RAM: writes BG, then read/invert,
// reverse read/invert and a final read, reporting pass and the first mismatch.
//
//   state    | meaning
//   IDLE     | waiting for start
//   E0_WR    | el0: ascending write of BG, one cycle per address
//   RD       | el1/el2: hold address RD_LAT+1 cycles, compare in the last
//   WR       | el1/el2: write the inverted value to the same address
//   FIN      | el3: ascending read-only compare against BG
//   DONE     | one-cycle done pulse, then back to IDLE
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int                ADDR_W = 3,
  parameter int                DATA_W = 8,
  parameter int                RD_LAT = 1,
  parameter logic [DATA_W-1:0] BG     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_bad
    $error("ram_bist_ctrl: RD_LAT must be within 0..3");
  end

  localparam logic [1:0] RD_LAST = RD_LAT[1:0];

  state_e            state_q;
  logic [1:0]        el_q, rd_cnt_q, el_nx;
  logic              busy_q, done_q, pass_q, we_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q, fail_exp_q, din_q, exp_val;
  logic              ag_load, ag_load_down, ag_step, ag_down, ag_term;
  logic [ADDR_W-1:0] addr;
  logic              rd_last, mismatch;

  assign el_nx    = el_q + 2'd1;
  assign rd_last  = (rd_cnt_q == RD_LAST);
  assign exp_val  = EL_EXP_INV[el_q] ? ~BG : BG;
  assign mismatch = (ram_data_out != exp_val);

  always_comb begin
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    ag_down      = EL_DOWN[el_q];
    unique case (state_q)
      ST_IDLE: ag_load = start;
      ST_E0_WR, ST_WR: begin
        if (ag_term) begin
          ag_load      = 1'b1;
          ag_load_down = EL_DOWN[el_nx];
        end else begin
          ag_step = 1'b1;
        end
      end
      ST_FIN:  ag_step = rd_last && !mismatch && !ag_term;
      default: ;
    endcase
  end

  ram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ag_load),
    .load_down_i(ag_load_down),
    .step_i     (ag_step),
    .down_i     (ag_down),
    .addr_o     (addr),
    .term_o     (ag_term)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      el_q        <= '0;
      rd_cnt_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      we_q        <= 1'b0;
      din_q       <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_exp_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            el_q    <= '0;
            we_q    <= 1'b1;
            din_q   <= BG;
            state_q <= ST_E0_WR;
          end
        end
        ST_E0_WR: begin
          if (ag_term) begin
            el_q     <= el_nx;
            we_q     <= 1'b0;
            rd_cnt_q <= '0;
            state_q  <= ST_RD;
          end
        end
        ST_RD, ST_FIN: begin
          if (!rd_last) begin
            rd_cnt_q <= rd_cnt_q + 2'd1;
          end else if (mismatch) begin
            fail_addr_q <= addr;
            fail_data_q <= ram_data_out;
            fail_exp_q  <= exp_val;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else if (state_q == ST_RD) begin
            we_q    <= 1'b1;
            din_q   <= EL_WR_INV[el_q] ? ~BG : BG;
            state_q <= ST_WR;
          end else if (ag_term) begin
            pass_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            rd_cnt_q <= '0;
          end
        end
        ST_WR: begin
          we_q     <= 1'b0;
          rd_cnt_q <= '0;
          if (ag_term) begin
            el_q    <= el_nx;
            state_q <= EL_HAS_WR[el_nx] ? ST_RD : ST_FIN;
          end else begin
            state_q <= ST_RD;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_addr    = fail_addr_q;
  assign fail_data    = fail_data_q;
  assign fail_exp     = fail_exp_q;
  assign ram_write_en = we_q;
  assign ram_addr     = addr;
  assign ram_data_in  = din_q;

endmodule
